audio_fx_path: RTL and testbench

AUDIO_FX_PATH -- requirements
Module: audio_fx_path

---
 rtl/audio_fx_pkg.sv | 27 ++
 rtl/audio_fx_path_if.sv | 41 ++++
 rtl/sample_delay_ram.sv | 33 +++
 rtl/audio_fx_path.sv | 183 ++++++++++++++++++
 tb/tb_audio_fx_path.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/audio_fx_pkg.sv
// Shared definitions for the audio effects path: effect mode encodings and
// the mid-scale / saturation constants derived from the sample width.
package audio_fx_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_DELAY = 2'b01,
    MODE_ECHO  = 2'b10,
    MODE_MUTE  = 2'b11
  } fxMode_t;

  // Offset-binary zero point: the code a silent input produces.
  function automatic int midCode(input int dataW);
    return 1 << (dataW - 1);
  endfunction

  // Largest signed excursion above the zero point.
  function automatic int satMax(input int dataW);
    return midCode(dataW) - 1;
  endfunction

  // Largest signed excursion below the zero point.
  function automatic int satMin(input int dataW);
    return -midCode(dataW);
  endfunction

endpackage

// File: rtl/audio_fx_path_if.sv
// Control and sample-stream bundle between the converter-side logic and the
// effects path. The slave modport is the effects path itself.
interface audio_fx_path_if #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 1024
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic              tick_en;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] delay_len;
  logic [DATA_W-1:0] adc_data;
  logic              adc_valid;
  logic              sample_tick;
  logic [DATA_W-1:0] dac_data;
  logic              dac_valid;

  modport master (
    output tick_en,
    output mode,
    output delay_len,
    output adc_data,
    output adc_valid,
    input  sample_tick,
    input  dac_data,
    input  dac_valid
  );

  modport slave (
    input  tick_en,
    input  mode,
    input  delay_len,
    input  adc_data,
    input  adc_valid,
    output sample_tick,
    output dac_data,
    output dac_valid
  );

endinterface

// File: rtl/sample_delay_ram.sv
// Simple dual-port sample store for the delay line: one synchronous write
// port and one registered read port, written so it maps onto block RAM.
module sample_delay_ram #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_wrEn,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  logic [DATA_W-1:0] i_wrData,
  input  logic              i_rdEn,
  input  logic [ADDR_W-1:0] i_rdAddr,
  output logic [DATA_W-1:0] o_rdData
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Store the incoming sample; no reset so the array stays a plain RAM.
  always_ff @(posedge i_clk) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  // Registered read: data appears the cycle after the address is presented.
  always_ff @(posedge i_clk) begin
    if (i_rdEn) begin
      o_rdData <= r_mem[i_rdAddr];
    end
  end

endmodule

// File: rtl/audio_fx_path.sv
// Audio effects path: sample-rate tick generator plus a two-stage sample
// pipeline offering pass, delay, echo and mute on offset-binary samples.
// Stage 1 writes the new sample and reads the delayed one from RAM; stage 2
// applies the effect and registers the converter output.
module audio_fx_path
  import audio_fx_pkg::*;
#(
  parameter int DATA_W   = 10,
  parameter int DEPTH    = 1024,
  parameter int TICK_DIV = 5000
) (
  input  logic            CLOCK_50,
  input  logic            RESET_N,
  audio_fx_path_if.slave  fx
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(TICK_DIV);

  localparam logic [CNT_W-1:0]         TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0]        FILL_MAX  = '1;
  localparam logic [DATA_W-1:0]        MID       = DATA_W'(midCode(DATA_W));
  localparam logic signed [DATA_W+1:0] MID_S     = (DATA_W + 2)'(midCode(DATA_W));
  localparam logic signed [DATA_W+1:0] SAT_HI    = (DATA_W + 2)'(satMax(DATA_W));
  localparam logic signed [DATA_W+1:0] SAT_LO    = (DATA_W + 2)'(satMin(DATA_W));

  // Sample-rate tick state
  logic [CNT_W-1:0]  r_tickCnt;

  // Delay-line bookkeeping
  logic [ADDR_W-1:0] r_wrPtr;
  logic [ADDR_W-1:0] r_fill;
  logic [ADDR_W-1:0] w_len;
  logic [ADDR_W-1:0] w_rdAddr;
  logic              w_useMid;
  logic [DATA_W-1:0] w_ramData;

  // Stage 1: sample and its per-sample controls travelling alongside the RAM read
  logic              r_s1Valid;
  logic [DATA_W-1:0] r_s1X;
  fxMode_t           r_s1Mode;
  logic              r_s1UseMid;

  // Stage 2 arithmetic
  logic [DATA_W-1:0]        w_d;
  logic signed [DATA_W+1:0] w_xs;
  logic signed [DATA_W+1:0] w_ds;
  logic signed [DATA_W+1:0] w_y;
  logic signed [DATA_W+1:0] w_ySat;
  logic [DATA_W-1:0]        w_echo;
  logic [DATA_W-1:0]        w_procData;

  // Output registers
  logic              r_dacValid;
  logic [DATA_W-1:0] r_dacData;

  // ---------------------------------------------------------------------------
  // Sample tick
  // ---------------------------------------------------------------------------

  // Free-running divider that simply freezes while the tick is disabled.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_tickCnt <= '0;
    end else if (fx.tick_en) begin
      r_tickCnt <= (r_tickCnt == TICK_LAST) ? '0 : r_tickCnt + 1'b1;
    end
  end

  assign fx.sample_tick = fx.tick_en && (r_tickCnt == TICK_LAST);

  // ---------------------------------------------------------------------------
  // Delay-line addressing
  // ---------------------------------------------------------------------------

  // A zero delay would read the slot being written, so it is treated as one.
  assign w_len    = (fx.delay_len == '0) ? ADDR_W'(1) : fx.delay_len;
  assign w_rdAddr = r_wrPtr - w_len;
  assign w_useMid = (w_len > r_fill);

  // Advance the write pointer and count history depth on every accepted sample.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wrPtr <= '0;
      r_fill  <= '0;
    end else if (fx.adc_valid) begin
      r_wrPtr <= r_wrPtr + 1'b1;
      if (r_fill != FILL_MAX) begin
        r_fill <= r_fill + 1'b1;
      end
    end
  end

  sample_delay_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk    (CLOCK_50),
    .i_wrEn   (fx.adc_valid),
    .i_wrAddr (r_wrPtr),
    .i_wrData (fx.adc_data),
    .i_rdEn   (fx.adc_valid),
    .i_rdAddr (w_rdAddr),
    .o_rdData (w_ramData)
  );

  // ---------------------------------------------------------------------------
  // Stage 1
  // ---------------------------------------------------------------------------

  // Capture the sample together with the controls that apply to it.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_s1Valid  <= 1'b0;
      r_s1X      <= MID;
      r_s1Mode   <= MODE_PASS;
      r_s1UseMid <= 1'b1;
    end else begin
      r_s1Valid <= fx.adc_valid;
      if (fx.adc_valid) begin
        r_s1X      <= fx.adc_data;
        r_s1Mode   <= fxMode_t'(fx.mode);
        r_s1UseMid <= w_useMid;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 arithmetic
  // ---------------------------------------------------------------------------

  // History not yet written reads as silence rather than stale RAM contents.
  assign w_d  = r_s1UseMid ? MID : w_ramData;

  assign w_xs = $signed({2'b00, r_s1X}) - MID_S;
  assign w_ds = $signed({2'b00, w_d}) - MID_S;
  assign w_y  = w_xs + (w_ds >>> 1);

  // Clamp the echo sum to the signed range representable by the DAC code.
  always_comb begin
    w_ySat = w_y;
    if (w_y > SAT_HI) begin
      w_ySat = SAT_HI;
    end else if (w_y < SAT_LO) begin
      w_ySat = SAT_LO;
    end
  end

  assign w_echo = DATA_W'(w_ySat + MID_S);

  // Select the processed sample according to the mode carried with it.
  always_comb begin
    w_procData = r_s1X;
    case (r_s1Mode)
      MODE_PASS:  w_procData = r_s1X;
      MODE_DELAY: w_procData = w_d;
      MODE_ECHO:  w_procData = w_echo;
      MODE_MUTE:  w_procData = MID;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------

  // Register the DAC sample; the data holds between valid strobes.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_dacValid <= 1'b0;
      r_dacData  <= MID;
    end else begin
      r_dacValid <= r_s1Valid;
      if (r_s1Valid) begin
        r_dacData <= w_procData;
      end
    end
  end

  assign fx.dac_valid = r_dacValid;
  assign fx.dac_data  = r_dacData;

endmodule

// File: tb/tb_audio_fx_path.sv
// Directed bench for audio_fx_path with hand-computed expectations:
// reset state, tick timing, pass latency, delay fill, echo saturation,
// per-sample mode changes, pointer wrap and mid-pipeline reset.
module tb_audio_fx_path;
  import audio_fx_pkg::*;

  localparam int DATA_W   = 10;
  localparam int DEPTH    = 1024;
  localparam int TICK_DIV = 5000;
  localparam int MAXB     = 1100;

  logic clock50 = 1'b0;
  logic resetN  = 1'b0;

  int errors = 0;
  int checks = 0;

  logic              obsValid;
  logic [DATA_W-1:0] obsData;
  logic              obsTick;

  int tickAt[$];
  int expTick[4] = '{4999, 9999, 14999, 20099};

  logic [1:0]        bMode [MAXB];
  logic [9:0]        bLen  [MAXB];
  logic [DATA_W-1:0] bData [MAXB];
  logic [DATA_W-1:0] bExp  [MAXB];

  audio_fx_path_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) fxIf ();

  audio_fx_path #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .CLOCK_50 (clock50),
    .RESET_N  (resetN),
    .fx       (fxIf)
  );

  // 50 MHz system clock
  always #10 clock50 = ~clock50;

  task applyStimulus(input logic v, input logic [1:0] m, input logic [9:0] dl,
                     input logic [DATA_W-1:0] d);
    fxIf.adc_valid = v;
    fxIf.mode      = m;
    fxIf.delay_len = dl;
    fxIf.adc_data  = d;
  endtask

  // Sample outputs mid-cycle, then move to just after the next rising edge.
  task stepCycle;
    @(negedge clock50);
    obsValid = fxIf.dac_valid;
    obsData  = fxIf.dac_data;
    obsTick  = fxIf.sample_tick;
    @(posedge clock50);
    #1;
  endtask

  task checkOutput(input string tag, input logic [31:0] observed,
                   input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task resetDut;
    applyStimulus(1'b0, MODE_PASS, 10'd0, '0);
    resetN = 1'b0;
    @(posedge clock50);
    #1;
    resetN = 1'b1;
  endtask

  // Feed n back-to-back samples from the burst tables and check each output
  // two cycles later, followed by one idle output.
  task runBurst(input string tag, input int n);
    for (int c = 0; c < n + 3; c++) begin
      if (c < n) applyStimulus(1'b1, bMode[c], bLen[c], bData[c]);
      else       applyStimulus(1'b0, MODE_PASS, 10'd0, '0);
      stepCycle();
      if (c < 2 || c >= n + 2) begin
        checkOutput($sformatf("%s_idle_valid[%0d]", tag, c), 32'(obsValid), 32'd0);
      end else begin
        checkOutput($sformatf("%s_valid[%0d]", tag, c - 2), 32'(obsValid), 32'd1);
        checkOutput($sformatf("%s_data[%0d]", tag, c - 2), 32'(obsData), 32'(bExp[c - 2]));
      end
    end
  endtask

  initial begin
    // Reset state
    fxIf.tick_en = 1'b1;
    applyStimulus(1'b0, MODE_PASS, 10'd0, '0);
    resetN = 1'b0;
    stepCycle();
    checkOutput("rst_tick", 32'(obsTick), 32'd0);
    checkOutput("rst_valid", 32'(obsValid), 32'd0);
    checkOutput("rst_data", 32'(obsData), 32'd512);
    resetN = 1'b1;

    // Tick timing with a 100-cycle enable drop exactly on the terminal count
    for (int cyc = 0; cyc < 20200; cyc++) begin
      fxIf.tick_en = !(cyc >= 19999 && cyc < 20099);
      stepCycle();
      if (obsTick) tickAt.push_back(cyc);
    end
    fxIf.tick_en = 1'b0;
    checkOutput("tick_count", 32'(tickAt.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("tick_at[%0d]", i),
                  (i < tickAt.size()) ? 32'(tickAt[i]) : 32'hFFFF_FFFF, 32'(expTick[i]));
    end

    // Pass mode latency and hold
    applyStimulus(1'b1, MODE_PASS, 10'd0, 10'h2A5);
    stepCycle();
    applyStimulus(1'b0, MODE_PASS, 10'd0, '0);
    stepCycle();
    checkOutput("pass_t1_valid", 32'(obsValid), 32'd0);
    stepCycle();
    checkOutput("pass_t2_valid", 32'(obsValid), 32'd1);
    checkOutput("pass_t2_data", 32'(obsData), 32'h2A5);
    stepCycle();
    checkOutput("pass_t3_valid", 32'(obsValid), 32'd0);
    checkOutput("pass_t3_hold", 32'(obsData), 32'h2A5);

    // Delay of 3 on a ramp: three silent outputs, then the ramp 3 behind
    resetDut();
    for (int k = 0; k < 10; k++) begin
      bMode[k] = MODE_DELAY;
      bLen[k]  = 10'd3;
      bData[k] = 10'(k + 1);
      bExp[k]  = (k < 3) ? 10'd512 : 10'(k - 2);
    end
    runBurst("delay3", 10);

    // Delay length 0 behaves as 1
    resetDut();
    for (int k = 0; k < 4; k++) begin
      bMode[k] = MODE_DELAY;
      bLen[k]  = 10'd0;
      bData[k] = 10'(100 * (k + 1));
      bExp[k]  = (k == 0) ? 10'd512 : 10'(100 * k);
    end
    runBurst("delay0", 4);

    // Echo with saturation at both rails
    resetDut();
    bData[0] = 10'd700;  bExp[0] = 10'd700;
    bData[1] = 10'd600;  bExp[1] = 10'd694;
    bData[2] = 10'd1023; bExp[2] = 10'd1023;
    bData[3] = 10'd1023; bExp[3] = 10'd1023;
    bData[4] = 10'd0;    bExp[4] = 10'd255;
    bData[5] = 10'd0;    bExp[5] = 10'd0;
    for (int k = 0; k < 6; k++) begin
      bMode[k] = MODE_ECHO;
      bLen[k]  = 10'd1;
    end
    runBurst("echo", 6);

    // Mode and delay length change from one sample to the next
    resetDut();
    bMode[0] = MODE_PASS;  bLen[0] = 10'd0; bData[0] = 10'd300; bExp[0] = 10'd300;
    bMode[1] = MODE_MUTE;  bLen[1] = 10'd0; bData[1] = 10'd400; bExp[1] = 10'd512;
    bMode[2] = MODE_DELAY; bLen[2] = 10'd1; bData[2] = 10'd500; bExp[2] = 10'd400;
    bMode[3] = MODE_PASS;  bLen[3] = 10'd0; bData[3] = 10'd600; bExp[3] = 10'd600;
    bMode[4] = MODE_ECHO;  bLen[4] = 10'd2; bData[4] = 10'd100; bExp[4] = 10'd94;
    bMode[5] = MODE_DELAY; bLen[5] = 10'd3; bData[5] = 10'd0;   bExp[5] = 10'd500;
    runBurst("mixed", 6);

    // Maximum delay across the write-pointer wrap
    resetDut();
    for (int k = 0; k < 1030; k++) begin
      bMode[k] = MODE_DELAY;
      bLen[k]  = 10'd1023;
      bData[k] = 10'((k * 37 + 5) % 1024);
      bExp[k]  = (k < 1023) ? 10'd512 : bData[k - 1023];
    end
    runBurst("wrap", 1030);

    // Reset while a sample is in flight discards it
    applyStimulus(1'b1, MODE_PASS, 10'd0, 10'h155);
    stepCycle();
    applyStimulus(1'b0, MODE_PASS, 10'd0, '0);
    resetN = 1'b0;
    #2;
    checkOutput("midrst_async_valid", 32'(fxIf.dac_valid), 32'd0);
    checkOutput("midrst_async_data", 32'(fxIf.dac_data), 32'd512);
    @(negedge clock50);
    resetN = 1'b1;
    @(posedge clock50);
    #1;
    stepCycle();
    checkOutput("midrst_t2_valid", 32'(obsValid), 32'd0);
    checkOutput("midrst_t2_data", 32'(obsData), 32'd512);
    stepCycle();
    checkOutput("midrst_t3_valid", 32'(obsValid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
